// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter
// Shares one burst bus to low memory between the I-cache refill port and the
// D-cache refill/write-back port. A winner is picked only while idle, owns the
// bus for a full BURST_LEN-beat burst, and gets ready/read data steered back.
// Build option: define ARB_TIMEOUT_EN to enable the 8-bit stall watchdog that
// aborts a burst after 255 granted cycles without mem_ready and pulses arb_err.
module cache_bus_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_as,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic [DATA_W-1:0] ic_rd_data,
   output logic              ic_ready,
   input  logic              dc_as,
   input  logic              dc_rw,
   input  logic [ADDR_W-1:0] dc_rd_addr,
   input  logic [ADDR_W-1:0] dc_wr_addr,
   input  logic [DATA_W-1:0] dc_wr_data,
   output logic [DATA_W-1:0] dc_rd_data,
   output logic              dc_ready,
   output logic              mem_as,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic              mem_ready,
   output logic              arb_err
);

   // Beat index width; one beat is one 4-byte word of the block.
   localparam int BEAT_W = $clog2(BURST_LEN);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   // Clears the in-block offset bits so the beat index can be OR'd in.
   localparam logic [ADDR_W-1:0] BLK_MASK = ~(ADDR_W'(BURST_LEN * 4 - 1));

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GNT_I = 2'd1;
   localparam logic [1:0] ST_GNT_D = 2'd2;

   // Control state (reset)
   logic [1:0]        state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              rw_q, rw_d;
   logic              last_gnt_d_q, last_gnt_d_d;   // 1: D-cache had the last grant

   // Latched block base address (data, not reset; only observed while granted)
   logic [ADDR_W-1:0] base_q, base_d;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] WDOG_LAST = 8'd254;        // 255th stalled cycle aborts
   logic [7:0]        wdog_q, wdog_d;
   logic              err_q, err_d;
`endif

   logic              win_i;
   logic              win_d;
   logic              granted;
   logic              own_i;
   logic              own_d;
   logic [ADDR_W-1:0] beat_off;
   logic [ADDR_W-1:0] dc_base;

   // Round-robin pick among pending requesters; a tie goes to whoever did not win last.
   always_comb begin
      win_i = ic_as & (~dc_as | last_gnt_d_q);
      win_d = dc_as & (~ic_as | ~last_gnt_d_q);
   end

   // D-cache base selection by transfer direction, aligned to the block.
   always_comb begin
      dc_base = (dc_rw ? dc_wr_addr : dc_rd_addr) & BLK_MASK;
   end

   // Next-state logic: arbitration in IDLE, beat counting while granted.
   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      rw_d         = rw_q;
      last_gnt_d_d = last_gnt_d_q;
      base_d       = base_q;
`ifdef ARB_TIMEOUT_EN
      wdog_d       = wdog_q;
      err_d        = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            beat_d = '0;
            if (win_i) begin
               state_d      = ST_GNT_I;
               base_d       = ic_addr & BLK_MASK;
               rw_d         = 1'b0;
               last_gnt_d_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
               wdog_d       = '0;
`endif
            end else if (win_d) begin
               state_d      = ST_GNT_D;
               base_d       = dc_base;
               rw_d         = dc_rw;
               last_gnt_d_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
               wdog_d       = '0;
`endif
            end
         end
         ST_GNT_I, ST_GNT_D: begin
            if (mem_ready) begin
`ifdef ARB_TIMEOUT_EN
               wdog_d = '0;
`endif
               if (beat_q == LAST_BEAT) begin
                  state_d = ST_IDLE;
                  beat_d  = '0;
               end else begin
                  beat_d  = beat_q + BEAT_W'(1);
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (wdog_q == WDOG_LAST) begin
               // Memory has stalled too long: drop the burst and flag it.
               state_d = ST_IDLE;
               beat_d  = '0;
               wdog_d  = '0;
               err_d   = 1'b1;
            end else begin
               wdog_d  = wdog_q + 8'd1;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            beat_d  = '0;
         end
      endcase
   end

   // Control registers with synchronous reset; reset aborts any burst at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         beat_q       <= '0;
         rw_q         <= 1'b0;
         last_gnt_d_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         wdog_q       <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         rw_q         <= rw_d;
         last_gnt_d_q <= last_gnt_d_d;
`ifdef ARB_TIMEOUT_EN
         wdog_q       <= wdog_d;
         err_q        <= err_d;
`endif
      end
   end

   // Base address register, loaded on grant entry and held for the burst.
   always_ff @(posedge clk) begin
      base_q <= base_d;
   end

   // Ownership decode and current beat byte offset.
   always_comb begin
      granted  = (state_q == ST_GNT_I) | (state_q == ST_GNT_D);
      own_i    = (state_q == ST_GNT_I);
      own_d    = (state_q == ST_GNT_D);
      beat_off = ADDR_W'({beat_q, 2'b00});
   end

   // Memory-side outputs; everything reads zero while idle.
   always_comb begin
      mem_as      = granted;
      mem_rw      = granted & rw_q;
      mem_addr    = granted ? (base_q | beat_off) : '0;
      mem_wr_data = (own_d & rw_q) ? dc_wr_data : '0;
   end

   // Steer handshake and read data to the current owner only.
   always_comb begin
      ic_ready   = own_i & mem_ready;
      dc_ready   = own_d & mem_ready;
      ic_rd_data = (own_i & ~rw_q) ? mem_rd_data : '0;
      dc_rd_data = (own_d & ~rw_q) ? mem_rd_data : '0;
   end

`ifdef ARB_TIMEOUT_EN
   assign arb_err = err_q;
`else
   assign arb_err = 1'b0;
`endif

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Shares the single low-memory burst bus between the I-cache refill port (read-only) and the D-cache port (read refill or dirty write-back).
- Grants one requester at a time and holds the grant for a whole BURST_LEN-beat burst.
- Generates per-beat addresses and steers ready and read data back to the owner.
- Sits between both caches' bus_* outputs and the memory/AXI bridge.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data beat width
BURST_LEN, 16, beats per block transfer (power of 2, 2..16)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
ic_as  in  1  I-cache burst request (read)
ic_addr  in  ADDR_W  I-cache block base address
ic_rd_data  out  DATA_W  read beat to I-cache
ic_ready  out  1  beat accepted/valid for I-cache
dc_as  in  1  D-cache burst request
dc_rw  in  1  0 read, 1 write
dc_rd_addr  in  ADDR_W  D-cache refill base address
dc_wr_addr  in  ADDR_W  D-cache write-back base address
dc_wr_data  in  DATA_W  write beat from D-cache
dc_rd_data  out  DATA_W  read beat to D-cache
dc_ready  out  1  beat accepted/valid for D-cache
mem_as  out  1  bus request to memory
mem_rw  out  1  0 read, 1 write
mem_addr  out  ADDR_W  current beat address
mem_wr_data  out  DATA_W  write beat to memory
mem_rd_data  in  DATA_W  read beat from memory
mem_ready  in  1  beat handshake from memory
arb_err  out  1  one-cycle timeout error pulse

Behaviour:
- Reset: synchronous, active-high, on clk. All outputs 0. State IDLE, beat counter 0, last_grant=I. Reset mid-burst aborts immediately; mem_as is 0 from the next edge.
- States: IDLE, GNT_I, GNT_D.
- IDLE:
  - Requests are sampled only here.
  - Only ic_as -> GNT_I. Only dc_as -> GNT_D.
  - Both asserted -> grant the requester opposite last_grant (round-robin). After reset, D wins the first tie.
- On grant entry (registered), latch:
  - base address: ic_addr, or dc_rd_addr / dc_wr_addr selected by dc_rw;
  - rw: 0 for I, dc_rw for D.
  - Update last_grant.
- Latency: a request first seen high in IDLE at edge N gives mem_as=1 from edge N+1.
- While granted:
  - mem_as=1.
  - mem_rw = latched rw.
  - mem_addr = base + (beat << 2); beat is log2(BURST_LEN) bits, base low bits ignored.
  - mem_wr_data = dc_wr_data when GNT_D and write, else 0.
- Steering:
  - Owner ready = mem_ready.
  - Owner rd_data = mem_rd_data when reading, else 0.
  - Non-owner ready=0, rd_data=0.
- Beat counter increments on each mem_ready while granted.
- On mem_ready with beat==BURST_LEN-1: return to IDLE and clear beat; mem_as=0 the following cycle.
- At least one IDLE cycle always separates bursts, so mem_as drops for at least 1 cycle between bursts.
- Requester deasserting as mid-burst does not abort; the burst runs to completion. Address/rw changes mid-burst are ignored (latched values used).
- mem_ready while IDLE is ignored.
- A requester still asserting as after its burst ends is re-arbitrated normally. The other requester wins if both are pending.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: 8-bit watchdog counts granted cycles without mem_ready; it resets on any mem_ready or grant entry. On reaching 255:
  - abort the burst to IDLE;
  - pulse arb_err for 1 cycle;
  - beat counter cleared;
  - owner sees no further ready.
- Not defined: no watchdog; arb_err tied 0; bursts wait indefinitely for mem_ready.

Test Plan:
- I-cache read: ic_as=1, ic_addr=0x0000_1040, mem_ready every cycle -> mem_as high 16 cycles, mem_addr 0x1040..0x107C step 4, ic_ready 16 pulses, dc_ready stays 0, mem_as low after.
- D-cache write-back: dc_as=1, dc_rw=1, dc_wr_addr=0x0000_2000, dc_wr_data=beat index -> mem_rw=1, mem_wr_data 0..15 on addresses 0x2000..0x203C, then IDLE.
- Tie after reset: ic_as=dc_as=1 together -> D burst first; one IDLE cycle; then I burst; a third tie grants D again.
- Throttled bus: mem_ready asserted every 3rd cycle -> beat counter and mem_addr advance only on ready; exactly 16 beats; end state IDLE.
- Reset at beat 7 of a D-read -> next cycle mem_as=0, dc_ready=0, beat=0; a new ic_as is granted from IDLE with first address = base.
- With ARB_TIMEOUT_EN: grant then mem_ready held 0 -> arb_err pulses once after 255 cycles, state IDLE. Without the macro: mem_as stays high, arb_err=0.
